tis100_stack: RTL
=================

# tis100_stack

Stack memory node for the TIS-100 fabric. It sits directly beside compute nodes (`tis100`) on the same 15-bit directional port buses and acts as a neighbour they push to and pop from with `MOV`/`ANY`. Writes from any side are pushed onto a LIFO, and reads from any side are served from the top. Arbitration and handshake semantics match a compute node's port behaviour.

## Interface
Parameters:
- `DEPTH`, 15, number of stack entries (TIS-100 stack capacity).
- `CW`, 4, count width; must satisfy 2^CW > DEPTH.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `left`, `right`, `up`, `down`  in  15 each  bus from that neighbour.
- `leftOut`, `rightOut`, `upOut`, `downOut`  out  15 each  bus to that neighbour.
- `count`  out  CW  current number of stored words.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.

Bus format (both directions): [10:0] signed data, [11] valid (sender offers data), [12] rdreq (sender waiting to read), [13] ack (sender consumed the offered word), [14] reserved, driven 0.

## Operation
- Storage: DEPTH × 11-bit signed register array plus a pointer `sp` (= `count`). There is no arithmetic on data; words pass through bit-exact, so −999 stays −999.
- Arbitration order for simultaneous candidates is LEFT, RIGHT, UP, DOWN, both for push and pop selection.
- FSM states:
  - IDLE:
    - Push when some port p has valid = 1, p is not the port acked last cycle, and `full` = 0. Take the highest-priority such p: `mem[sp] <= data`, `sp <= sp+1`, and assert ack on `pOut` next cycle for exactly one cycle. Stay in IDLE.
    - Otherwise, if `empty` = 0 and some port has rdreq = 1, latch the highest-priority such port into `sel` and go to OFFER.
    - A push takes precedence over starting an offer in the same cycle.
  - OFFER:
    - Drive `selOut` with data = `mem[sp-1]` and valid = 1. All other out buses carry valid = 0.
    - If `sel`'s ack = 1: `sp <= sp-1`, valid drops next cycle, go to IDLE.
    - Else if `sel`'s rdreq = 0 (reader withdrew, e.g. its `ANY` was satisfied elsewhere): withdraw the offer with no pop, go to IDLE.
    - Incoming pushes are not accepted in OFFER, so top-of-stack stays stable while offered.
- Full: valid writers are stalled with no ack and keep holding valid. Empty: readers are ignored, and the node stays in IDLE.
- Unused out bits (rdreq, reserved) are always 0; the stack never initiates reads.

## Timing
- Reset values: every out bus = 15'h0000, `count` = 0, `empty` = 1, `full` = 0, state = IDLE, `sel` = LEFT. Memory contents are don't-care.
- Reset mid-operation drops any pending offer or ack at once. A writer that was stalled re-pushes after reset is released.
- Push latency: writer valid sampled at edge N, ack visible after edge N+1 for one cycle, `count` updated after edge N+1. Back-to-back pushes from different ports are possible every cycle.
- A same-port repeat push needs the writer to drop valid for the ack cycle. Valid from the acked port is ignored during its ack cycle, so no double push.
- Pop latency: rdreq sampled at edge N, offer valid after edge N+1. Reader ack sampled at edge M, offer withdrawn and `count` decremented after edge M+1.
- Minimum push-then-pop turnaround is 3 cycles.
- `full` and `empty` are combinational from `count`.

## Structure
- Shared package/include: the bus bit positions (DATA_MSB = 10, VALID = 11, RDREQ = 12, ACK = 13), the port index encoding (LEFT = 0, RIGHT = 1, UP = 2, DOWN = 3), and the FSM state encodings. `tis100` uses the same definitions.
- One sub-module is natural: `tis100_port_arb`, a 4-input fixed-priority picker (LEFT > RIGHT > UP > DOWN) returning a one-hot grant and a 2-bit index. Instantiate it twice, once for push and once for pop.

## Test plan
- Reset then idle: after `reset` deasserts, every out bus = 0, `count` = 0, `empty` = 1, and no ack appears with all inputs quiet.
- Single push/pop: LEFT pushes 5 → ack on `leftOut`, `count` = 1. RIGHT raises rdreq → `rightOut` shows data 5 with valid, RIGHT acks → `count` = 0, valid drops next cycle.
- LIFO order: UP pushes 1, 2, 3 (−999 as a fourth) → DOWN pops −999, 3, 2, 1 in that order, and `empty` = 1 at the end.
- Simultaneous arbitration: LEFT, UP and DOWN all present valid with 7, 8, 9 in the same cycle → order of acceptance is LEFT, UP, DOWN, and the pops return 9, 8, 7.
- Full stall: fill with 15 pushes → `full` = 1. A 16th valid from RIGHT gets no ack until one pop occurs, then it is accepted and `count` returns to 15.
- Withdraw and reset: offer to UP, UP drops rdreq without ack → `count` unchanged, offer removed. Assert `reset` during a later offer → out buses go to 0 immediately and `count` = 0.

Source files
------------

// File: rtl/tis100_stack_pkg.sv
// rtl/tis100_stack_pkg.sv - shared bus layout, port indices and FSM states for TIS-100 nodes
package tis100_stack_pkg;

    localparam int BUS_W    = 15;
    localparam int DATA_MSB = 10;
    localparam int VALID    = 11;
    localparam int RDREQ    = 12;
    localparam int ACK      = 13;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } port_e;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    // rdreq and the reserved bit stay 0: the stack never initiates a read
    function automatic logic [BUS_W-1:0] bus_word(input logic [DATA_MSB:0] data,
                                                  input logic valid,
                                                  input logic ack);
        bus_word              = '0;
        bus_word[DATA_MSB:0]  = data;
        bus_word[VALID]       = valid;
        bus_word[ACK]         = ack;
    endfunction

endpackage

// File: rtl/tis100_port_arb.sv
// rtl/tis100_port_arb.sv - fixed-priority picker, LEFT > RIGHT > UP > DOWN
module tis100_port_arb (
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       any
);

    always_comb begin
        grant = 4'b0000;
        idx   = 2'd0;
        any   = |req;
        if (req[0]) begin
            grant = 4'b0001;
            idx   = 2'd0;
        end else if (req[1]) begin
            grant = 4'b0010;
            idx   = 2'd1;
        end else if (req[2]) begin
            grant = 4'b0100;
            idx   = 2'd2;
        end else if (req[3]) begin
            grant = 4'b1000;
            idx   = 2'd3;
        end
    end

endmodule

// File: rtl/tis100_stack.sv
// rtl/tis100_stack.sv - LIFO stack node serving pushes and pops on the four port buses
module tis100_stack
    import tis100_stack_pkg::*;
#(
    parameter int DEPTH = 15,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [14:0]   left,
    input  logic [14:0]   right,
    input  logic [14:0]   up,
    input  logic [14:0]   down,
    output logic [14:0]   leftOut,
    output logic [14:0]   rightOut,
    output logic [14:0]   upOut,
    output logic [14:0]   downOut,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [ACK:0]      bus_in  [4];
    logic [BUS_W-1:0]  bus_out [4];
    logic [DATA_MSB:0] mem [DEPTH];

    logic [CW-1:0] sp;
    state_e        state;
    port_e         sel;
    logic [3:0]    acked;

    logic [3:0]        push_req, pop_req, push_grant, pop_grant;
    logic [1:0]        push_idx, pop_idx;
    logic              push_any, pop_any;
    logic [DATA_MSB:0] push_data, top_word;
    logic              unused;

    assign bus_in[0] = left[ACK:0];
    assign bus_in[1] = right[ACK:0];
    assign bus_in[2] = up[ACK:0];
    assign bus_in[3] = down[ACK:0];

    assign leftOut  = bus_out[0];
    assign rightOut = bus_out[1];
    assign upOut    = bus_out[2];
    assign downOut  = bus_out[3];

    assign count = sp;
    assign full  = (sp == CW'(DEPTH));
    assign empty = (sp == '0);

    // the port acked last cycle is masked so its still-high valid is not pushed twice
    always_comb begin
        push_req = '0;
        pop_req  = '0;
        for (int i = 0; i < 4; i++) begin
            push_req[i] = (state == IDLE) && bus_in[i][VALID] && !acked[i] && !full;
            pop_req[i]  = (state == IDLE) && bus_in[i][RDREQ] && !empty;
        end
    end

    tis100_port_arb u_push_arb (
        .req   (push_req),
        .grant (push_grant),
        .idx   (push_idx),
        .any   (push_any)
    );

    tis100_port_arb u_pop_arb (
        .req   (pop_req),
        .grant (pop_grant),
        .idx   (pop_idx),
        .any   (pop_any)
    );

    assign push_data = bus_in[push_idx][DATA_MSB:0];
    assign top_word  = mem[sp - 1'b1];
    assign unused    = ^{left[14], right[14], up[14], down[14], pop_grant};

    always_ff @(posedge clk) begin
        if (push_any) begin
            mem[sp] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= LEFT;
            sp    <= '0;
            acked <= '0;
            for (int i = 0; i < 4; i++) begin
                bus_out[i] <= '0;
            end
        end else begin
            acked <= '0;
            for (int i = 0; i < 4; i++) begin
                bus_out[i] <= '0;
            end
            case (state)
                IDLE: begin
                    if (push_any) begin
                        sp                <= sp + 1'b1;
                        acked             <= push_grant;
                        bus_out[push_idx] <= bus_word('0, 1'b0, 1'b1);
                    end else if (pop_any) begin
                        sel              <= port_e'(pop_idx);
                        state            <= OFFER;
                        bus_out[pop_idx] <= bus_word(top_word, 1'b1, 1'b0);
                    end
                end
                OFFER: begin
                    if (bus_in[sel][ACK]) begin
                        sp    <= sp - 1'b1;
                        state <= IDLE;
                    end else if (!bus_in[sel][RDREQ]) begin
                        state <= IDLE;
                    end else begin
                        bus_out[sel] <= bus_word(top_word, 1'b1, 1'b0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
